alu_arbiter_seq: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters (req0, req1) using round-robin arbitration.
- Registers the operands and function select of the winning request, drives them to the ALU, then captures the ALU result and flags into a response register.
- Returns the response on a valid/ready channel tagged with the requester id.
- Sits between the issue front-ends and the shared ALU instance; one operation in flight at a time.

---
 rtl/alu_arbiter_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_arbiter_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_seq
//  Description : Round-robin arbiter that shares one combinational ALU between
//                two requesters. It registers the winning request's operands
//                and select into the alu_* outputs and holds them for one
//                ISSUE cycle. It then captures the ALU result and flags into a
//                response register that is returned on a valid/ready channel
//                tagged with the requester id. Only one operation is in flight
//                at a time.
//  Ports       : clk, rst_n (async, active low)
//                req{0,1}_valid/ready/a/b/sel/cin  - requester channels
//                alu_a/b/sel/cin  -> ALU,  alu_y/cout/neg/zero/ovf <- ALU
//                resp_valid/ready/id/y/cout/neg/zero/ovf - response channel
//                busy - high whenever the block is not idle
//  Option      : `define ALU_ARB_STATS_EN adds stats_clr input and saturating
//                16-bit grant counters grant_cnt0 / grant_cnt1.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter_seq #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_y,
    output logic             resp_cout,
    output logic             resp_neg,
    output logic             resp_zero,
    output logic             resp_ovf,
`ifdef ALU_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_grant;   // id of the most recent winner
    logic   r_id;           // id of the op currently in flight

    logic             w_any;
    logic             w_grant_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [SEL_W-1:0] w_sel;
    logic             w_cin;

    // With both valid the winner is the one that did not win last time;
    // otherwise the single valid requester wins (req1_valid selects id 1).
    assign w_any      = req0_valid | req1_valid;
    assign w_grant_id = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept   = (r_state == S_IDLE) & w_any;

    assign req0_ready = w_accept & ~w_grant_id;
    assign req1_ready = w_accept &  w_grant_id;

    assign w_a   = w_grant_id ? req1_a   : req0_a;
    assign w_b   = w_grant_id ? req1_b   : req0_b;
    assign w_sel = w_grant_id ? req1_sel : req0_sel;
    assign w_cin = w_grant_id ? req1_cin : req0_cin;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            alu_cin      <= 1'b0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_y       <= '0;
            resp_cout    <= 1'b0;
            resp_neg     <= 1'b0;
            resp_zero    <= 1'b0;
            resp_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_a        <= w_a;
                        alu_b        <= w_b;
                        alu_sel      <= w_sel;
                        alu_cin      <= w_cin;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The ALU has had a full cycle on stable operands.
                    resp_y     <= alu_y;
                    resp_cout  <= alu_cout;
                    resp_neg   <= alu_neg;
                    resp_zero  <= alu_zero;
                    resp_ovf   <= alu_ovf;
                    resp_id    <= r_id;
                    resp_valid <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating grant counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (stats_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter_seq
//  Description : Scoreboard bench for alu_arbiter_seq. A driver issues
//                directed and random requests, predicts grants from the
//                round-robin rule and queues expected responses. A monitor
//                compares every presented response against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter_seq;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_sel;
    logic        req1_valid, req1_ready, req1_cin;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_sel;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_sel;
    logic        alu_cin, alu_cout, alu_neg, alu_zero, alu_ovf;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_y;
    logic        resp_cout, resp_neg, resp_zero, resp_ovf;
    logic        busy;
`ifdef ALU_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] grant_cnt0, grant_cnt1;
    int          m_cnt0, m_cnt1;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: 0 idle, 1 issue, 2 response pending.
    int   m_state;
    logic m_last;
    logic [36:0] exp_q[$];   // {id, cout, neg, zero, ovf, y}

    alu_arbiter_seq #(.WIDTH(32), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sel(req0_sel), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sel(req1_sel), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_y(resp_y), .resp_cout(resp_cout), .resp_neg(resp_neg),
        .resp_zero(resp_zero), .resp_ovf(resp_ovf),
`ifdef ALU_ARB_STATS_EN
        .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A.
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel, input logic cin);
        logic [32:0] s;
        logic [31:0] y;
        logic        co, ov;
        s = '0; co = 1'b0; ov = 1'b0;
        case (sel)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
                y = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                y = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (y[31] != a[31]);
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            default: y = a;
        endcase
        return {co, y[31], (y == 32'd0), ov, y};
    endfunction

    assign {alu_cout, alu_neg, alu_zero, alu_ovf, alu_y} = alu_f(alu_a, alu_b, alu_sel, alu_cin);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle a response is shown it must match the queue head
    // (which also proves it stays stable under backpressure); pop on handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", {63'd0, resp_valid}, 64'd0);
            end else begin
                chk("resp", {27'd0, resp_id, resp_cout, resp_neg, resp_zero, resp_ovf, resp_y},
                    {27'd0, exp_q[0]});
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; called 1 time unit after a rising edge.
    task automatic do_cycle(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                            input logic [3:0] s0, input logic c0,
                            input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                            input logic [3:0] s1, input logic c1,
                            input logic rr, output logic acc0, output logic acc1);
        int   nxt;
        logic id;
        chk("busy", {63'd0, busy}, {63'd0, (m_state != 0)});
        chk("resp_valid", {63'd0, resp_valid}, {63'd0, (m_state == 2)});
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", {48'd0, grant_cnt0}, 64'(m_cnt0));
        chk("grant_cnt1", {48'd0, grant_cnt1}, 64'(m_cnt1));
`endif
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1; req1_cin = c1;
        resp_ready = rr;
        #1;
        acc0 = 1'b0; acc1 = 1'b0; nxt = m_state;
        if (m_state == 0 && (v0 || v1)) begin
            id   = (v0 && v1) ? ~m_last : v1;
            acc0 = ~id; acc1 = id;
            exp_q.push_back(id ? {1'b1, alu_f(a1, b1, s1, c1)} : {1'b0, alu_f(a0, b0, s0, c0)});
            m_last = id;
            nxt = 1;
        end else if (m_state == 1) begin
            nxt = 2;
        end else if (m_state == 2 && rr) begin
            nxt = 0;
        end
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, acc0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, acc1});
`ifdef ALU_ARB_STATS_EN
        if (stats_clr) begin
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            if (acc0 && m_cnt0 < 65535) m_cnt0++;
            if (acc1 && m_cnt1 < 65535) m_cnt1++;
        end
`endif
        @(posedge clk);
        #1;
        m_state = nxt;
    endtask

    task automatic idle_cycles(input int n, input logic rr);
        logic x0, x1;
        for (int i = 0; i < n; i++)
            do_cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, rr, x0, x1);
    endtask

    logic        g0, g1;
    logic        p0v, p1v, p0c, p1c, rr;
    logic [31:0] p0a, p0b, p1a, p1b;
    logic [3:0]  p0s, p1s;

    initial begin
        rst_n = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0; req1_cin = 1'b0;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
`endif
        m_state = 0; m_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("rst_resp_y", {32'd0, resp_y}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op 5 + 3, response two edges after the accept.
        do_cycle(1'b1, 32'd5, 32'd3, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, g0, g1);
        idle_cycles(1, 1'b1);
        chk("single_resp_y", {32'd0, resp_y}, 64'd8);
        chk("single_resp_id", {63'd0, resp_id}, 64'd0);
        idle_cycles(1, 1'b1);

        // Overflow flags captured exactly.
        do_cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b1, g0, g1);
        idle_cycles(1, 1'b1);
        chk("flags_ovf_neg_zero", {61'd0, resp_ovf, resp_neg, resp_zero}, 64'b110);
        idle_cycles(1, 1'b1);

        // Contention: six back-to-back ops alternate 0,1,0,...
        for (int i = 0; i < 18; i++)
            do_cycle(1'b1, 32'(i), 32'd7, 4'd1, 1'b0, 1'b1, 32'(100 + i), 32'd9, 4'd4, 1'b1, 1'b1, g0, g1);

        // Backpressure: req1 waits through ten stalled response cycles.
        do_cycle(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, g0, g1);
        for (int i = 0; i < 11; i++)
            do_cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd44, 32'd55, 4'd3, 1'b0, 1'b0, g0, g1);
        do_cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd44, 32'd55, 4'd3, 1'b0, 1'b1, g0, g1);
        do_cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd44, 32'd55, 4'd3, 1'b0, 1'b1, g0, g1);
        chk("bp_req1_accepted", {63'd0, g1}, 64'd1);
        idle_cycles(2, 1'b1);

        // Async reset during ISSUE while req0 was the last winner.
        do_cycle(1'b1, 32'd1, 32'd1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, g0, g1);
        idle_cycles(2, 1'b1);
        do_cycle(1'b1, 32'd2, 32'd2, 4'd0, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, g0, g1);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("arst_alu", {alu_a, alu_b[27:0], alu_sel}, 64'd0);
        chk("arst_alu_cin", {63'd0, alu_cin}, 64'd0);
        exp_q.delete();
        m_state = 0; m_last = 1'b1;
`ifdef ALU_ARB_STATS_EN
        m_cnt0 = 0; m_cnt1 = 0;
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(1'b1, 32'd3, 32'd4, 4'd0, 1'b0, 1'b1, 32'd5, 32'd6, 4'd0, 1'b0, 1'b1, g0, g1);
        chk("arst_req0_wins", {62'd0, g1, g0}, 64'b01);
        idle_cycles(2, 1'b1);

        // Random traffic with held payloads, withdrawals and backpressure.
        p0v = 1'b0; p1v = 1'b0;
        p0a = '0; p0b = '0; p0s = '0; p0c = 1'b0;
        p1a = '0; p1b = '0; p1s = '0; p1c = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0v && $urandom_range(0, 1) == 0) begin
                p0v = 1'b1; p0a = $urandom; p0b = ($urandom_range(0, 3) == 0) ? p0a : $urandom;
                p0s = 4'($urandom_range(0, 7)); p0c = 1'($urandom);
            end else if (p0v && $urandom_range(0, 15) == 0) begin
                p0v = 1'b0;
            end
            if (!p1v && $urandom_range(0, 1) == 0) begin
                p1v = 1'b1; p1a = $urandom; p1b = ($urandom_range(0, 3) == 0) ? p1a : $urandom;
                p1s = 4'($urandom_range(0, 7)); p1c = 1'($urandom);
            end else if (p1v && $urandom_range(0, 15) == 0) begin
                p1v = 1'b0;
            end
            rr = ($urandom_range(0, 3) != 0);
`ifdef ALU_ARB_STATS_EN
            stats_clr = ($urandom_range(0, 24) == 0);
`endif
            do_cycle(p0v, p0a, p0b, p0s, p0c, p1v, p1a, p1b, p1s, p1c, rr, g0, g1);
            if (g0) p0v = 1'b0;
            if (g1) p1v = 1'b0;
        end
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        idle_cycles(6, 1'b1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
